// File: rtl/fighter_anim_ctrl.sv
// Per-fighter animation sequencer feeding selanim/selframe of the moving-sprite memory.
// Optional macro ANIM_HITBOX_EN adds a registered active-frame flag on hit_window.
`timescale 1ns/1ps
module fighter_anim_ctrl #(
  parameter int unsigned FRAME_TICKS = 6,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       req_walk,
  input  logic       req_jump,
  input  logic       req_crouch,
  input  logic       req_block,
  input  logic       req_punch,
  input  logic       req_kick,
  input  logic       got_hit,
  output logic [3:0] selanim,
  output logic [1:0] selframe,
  output logic       busy,
  output logic       anim_done,
  output logic       hit_window
);

  typedef enum logic [1:0] {
    ST_LOOP    = 2'd0,
    ST_ONESHOT = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  localparam logic [3:0] ANIM_IDLE    = 4'd0;
  localparam logic [3:0] ANIM_WALK    = 4'd1;
  localparam logic [3:0] ANIM_HIT     = 4'd2;
  localparam logic [3:0] ANIM_JUMP    = 4'd3;
  localparam logic [3:0] ANIM_LPUNCH  = 4'd4;
  localparam logic [3:0] ANIM_MPUNCH  = 4'd5;
  localparam logic [3:0] ANIM_HKICK   = 4'd6;
  localparam logic [3:0] ANIM_CROUCH  = 4'd7;
  localparam logic [3:0] ANIM_BLOCK_L = 4'd8;
  localparam logic [3:0] ANIM_BLOCK_H = 4'd9;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 1);

  state_e           state_q, state_d;
  logic [3:0]       anim_q, anim_d;
  logic [1:0]       frame_q, frame_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0] dec_code;
  state_e     dec_state;
  logic       advance;
  logic       restart;
  logic       finish;

  // Request decode, first match wins, plus the state class of the decoded code
  always_comb begin
    dec_code = ANIM_IDLE;
    if (req_jump)        dec_code = ANIM_JUMP;
    else if (req_punch)  dec_code = req_crouch ? ANIM_LPUNCH : ANIM_MPUNCH;
    else if (req_kick)   dec_code = ANIM_HKICK;
    else if (req_block)  dec_code = req_crouch ? ANIM_BLOCK_L : ANIM_BLOCK_H;
    else if (req_crouch) dec_code = ANIM_CROUCH;
    else if (req_walk)   dec_code = ANIM_WALK;

    dec_state = ST_LOOP;
    if (dec_code >= ANIM_CROUCH)    dec_state = ST_HOLD;
    else if (dec_code >= ANIM_HIT)  dec_state = ST_ONESHOT;
  end

  assign advance = tick && (cnt_q == CNT_LAST);
  assign restart = (state_q != ST_ONESHOT) && (dec_code != anim_q);
  assign finish  = (state_q == ST_ONESHOT) && advance && (frame_q == 2'd3);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_LOOP;
    else       state_q <= state_d;
  end

  // Next-state logic; a hit always wins over completion and decode
  always_comb begin
    state_d = state_q;
    if (got_hit)      state_d = ST_ONESHOT;
    else if (finish)  state_d = ST_LOOP;
    else if (restart) state_d = dec_state;
  end

  // Output / datapath next values
  always_comb begin
    anim_d  = anim_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (got_hit) begin
      anim_d  = ANIM_HIT;
      frame_d = 2'd0;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (restart) begin
      anim_d  = dec_code;
      frame_d = 2'd0;
      cnt_d   = '0;
      busy_d  = (dec_state == ST_ONESHOT);
    end else if (finish) begin
      anim_d  = ANIM_IDLE;
      frame_d = 2'd0;
      cnt_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end else if (tick) begin
      if (advance) begin
        cnt_d = '0;
        if (state_q != ST_HOLD) frame_d = frame_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anim_q  <= ANIM_IDLE;
      frame_q <= 2'd0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      anim_q  <= anim_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign selanim   = anim_q;
  assign selframe  = frame_q;
  assign busy      = busy_q;
  assign anim_done = done_q;

`ifdef ANIM_HITBOX_EN
  logic hitw_q, hitw_d;

  // Active frame of an attack is frame 2; tracks selframe on the same edge
  always_comb begin
    hitw_d = ((anim_d == ANIM_LPUNCH) || (anim_d == ANIM_MPUNCH) ||
              (anim_d == ANIM_HKICK)) && (frame_d == 2'd2);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) hitw_q <= 1'b0;
    else       hitw_q <= hitw_d;
  end

  assign hit_window = hitw_q;
`else
  assign hit_window = 1'b0;
`endif

endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// Directed self-checking bench for fighter_anim_ctrl (FRAME_TICKS=6).
`timescale 1ns/1ps
module tb_fighter_anim_ctrl;

  logic       clock;
  logic       reset;
  logic       tick;
  logic       req_walk, req_jump, req_crouch, req_block, req_punch, req_kick;
  logic       got_hit;
  logic [3:0] selanim;
  logic [1:0] selframe;
  logic       busy;
  logic       anim_done;
  logic       hit_window;

  int checks = 0;
  int errors = 0;

`ifdef ANIM_HITBOX_EN
  localparam int HW_ON = 1;
`else
  localparam int HW_ON = 0;
`endif

  fighter_anim_ctrl #(.FRAME_TICKS(6), .CNT_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .req_walk   (req_walk),
    .req_jump   (req_jump),
    .req_crouch (req_crouch),
    .req_block  (req_block),
    .req_punch  (req_punch),
    .req_kick   (req_kick),
    .got_hit    (got_hit),
    .selanim    (selanim),
    .selframe   (selframe),
    .busy       (busy),
    .anim_done  (anim_done),
    .hit_window (hit_window)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int a, input int f, input int b, input int d);
    chk({tag, ".selanim"},   int'(selanim),   a);
    chk({tag, ".selframe"},  int'(selframe),  f);
    chk({tag, ".busy"},      int'(busy),      b);
    chk({tag, ".anim_done"}, int'(anim_done), d);
  endtask

  // Issue n ticks, each a one-cycle pulse followed by an idle cycle; starts and ends at a negedge
  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clock);
      tick = 1'b0;
      @(negedge clock);
    end
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; got_hit = 1'b0;
    req_walk = 0; req_jump = 0; req_crouch = 0; req_block = 0; req_punch = 0; req_kick = 0;
    repeat (3) @(negedge clock);
    chk_all("reset_held", 0, 0, 0, 0);
    chk("reset_held.hit_window", int'(hit_window), 0);
    reset = 1'b0;
    @(negedge clock);
    chk_all("idle_start", 0, 0, 0, 0);

    // Idle loop: frame advances every 6 ticks and wraps
    tick_n(5);
    chk("idle_5ticks.selframe", int'(selframe), 0);
    tick_n(1);
    chk("idle_6ticks.selframe", int'(selframe), 1);
    repeat (20) @(negedge clock);
    chk("idle_no_tick.selframe", int'(selframe), 1);
    tick_n(6);
    chk("idle_f2.selframe", int'(selframe), 2);
    tick_n(6);
    chk("idle_f3.selframe", int'(selframe), 3);
    tick_n(6);
    chk_all("idle_wrap", 0, 0, 0, 0);

    // Walk held: same code does not restart
    req_walk = 1'b1;
    @(negedge clock);
    chk_all("walk_start", 1, 0, 0, 0);
    tick_n(6);
    chk_all("walk_no_restart", 1, 1, 0, 0);
    req_walk = 1'b0;
    @(negedge clock);
    chk_all("walk_release", 0, 0, 0, 0);

    // Mid punch with ignored requests during the attack
    req_punch = 1'b1;
    @(negedge clock);
    chk_all("punch_start", 5, 0, 1, 0);
    req_punch = 1'b0; req_kick = 1'b1; req_walk = 1'b1;
    tick_n(12);
    chk_all("punch_f2", 5, 2, 1, 0);
    chk("punch_f2.hit_window", int'(hit_window), HW_ON);
    tick_n(5);
    chk("punch_f2_end.hit_window", int'(hit_window), HW_ON);
    tick_n(1);
    chk_all("punch_f3", 5, 3, 1, 0);
    chk("punch_f3.hit_window", int'(hit_window), 0);
    tick_n(5);
    chk_all("punch_f3_late", 5, 3, 1, 0);
    req_kick = 1'b0; req_walk = 1'b0;
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    chk_all("punch_done", 0, 0, 0, 1);
    @(negedge clock);
    chk_all("punch_after", 0, 0, 0, 0);

    // Crouch then block low: frame stuck at 0
    req_crouch = 1'b1;
    @(negedge clock);
    chk_all("crouch", 7, 0, 0, 0);
    req_block = 1'b1;
    @(negedge clock);
    chk_all("block_low", 8, 0, 0, 0);
    tick_n(20);
    chk_all("block_low_20t", 8, 0, 0, 0);
    req_crouch = 1'b0;
    @(negedge clock);
    chk("block_high.selanim", int'(selanim), 9);
    req_block = 1'b0;
    @(negedge clock);
    chk_all("hold_release", 0, 0, 0, 0);

    // High kick interrupted by a hit at frame 2, then hit restarted at frame 1
    req_kick = 1'b1;
    @(negedge clock);
    chk_all("kick_start", 6, 0, 1, 0);
    req_kick = 1'b0;
    tick_n(12);
    chk_all("kick_f2", 6, 2, 1, 0);
    chk("kick_f2.hit_window", int'(hit_window), HW_ON);
    got_hit = 1'b1;
    @(negedge clock);
    got_hit = 1'b0;
    chk_all("hit_during_kick", 2, 0, 1, 0);
    chk("hit.hit_window", int'(hit_window), 0);
    tick_n(6);
    chk_all("hit_f1", 2, 1, 1, 0);
    got_hit = 1'b1;
    @(negedge clock);
    got_hit = 1'b0;
    chk_all("hit_restart", 2, 0, 1, 0);
    tick_n(5);
    chk("hit_restart_5t.selframe", int'(selframe), 0);
    tick_n(19);
    chk_all("hit_finished", 0, 0, 0, 0);

    // Jump whose final tick coincides with a hit
    req_jump = 1'b1;
    @(negedge clock);
    chk_all("jump_start", 3, 0, 1, 0);
    req_jump = 1'b0;
    tick_n(23);
    chk_all("jump_f3", 3, 3, 1, 0);
    tick = 1'b1; got_hit = 1'b1;
    @(negedge clock);
    tick = 1'b0; got_hit = 1'b0;
    chk_all("jump_hit_coincide", 2, 0, 1, 0);
    @(negedge clock);
    chk("jump_hit_after.anim_done", int'(anim_done), 0);

    // Asynchronous reset at hit frame 2
    tick_n(12);
    chk_all("hit2_f2", 2, 2, 1, 0);
    #2 reset = 1'b1;
    #1;
    chk_all("async_reset", 0, 0, 0, 0);
    chk("async_reset.hit_window", int'(hit_window), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk_all("post_reset", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
